// File: rtl/bitrev_reorder_ctrl_if.sv
// Purpose : valid/ready stream bundle for the bit-reverse reorder controller.
//           Carries the input stream (source -> controller) and the output
//           stream (controller -> FFT core) as one interface.
// Modports: master - sample source / sink side (drives in_*, out_ready)
//           slave  - reorder controller side (drives in_ready, out_*)
// Macro   : BITREV_BYPASS_EN adds the per-frame bypass request line.
interface bitrev_reorder_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef BITREV_BYPASS_EN
  logic              bypass;

  modport master (
    output in_valid, in_data, out_ready, bypass,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready, bypass,
    output in_ready, out_valid, out_data, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
`endif
endinterface

// File: rtl/bitrev_reorder_ctrl.sv
// Purpose : ping-pong frame buffer that accepts N=2**ADDR_W samples in natural
//           order and emits each frame in bit-reversed index order. One bank is
//           written while the other is read, giving one sample/cycle each side.
// Ports   : clk    - clock, all state on posedge
//           rst_n  - asynchronous active-low reset
//           io_bus - stream bundle (slave modport): in_valid/in_ready/in_data,
//                    out_valid/out_ready/out_data/out_last
// Macro   : BITREV_BYPASS_EN - adds io_bus.bypass; a frame captured with
//           bypass=1 is read back in natural order.
module bitrev_reorder_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitrev_reorder_ctrl_if.slave io_bus
);

  localparam int unsigned         N      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   CNT_LAST = ADDR_W'(N - 1);

  logic [DATA_W-1:0] r_mem [2][N];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;

  logic              w_in_acc;
  logic              w_out_acc;
  logic              w_wr_wrap;
  logic              w_rd_wrap;
  logic [ADDR_W-1:0] w_rev_cnt;
  logic [ADDR_W-1:0] w_rd_addr;

  // Handshake decode; both ready/valid come straight from registers.
  assign w_in_acc  = io_bus.in_valid & ~r_full[r_wr_bank];
  assign w_out_acc = r_full[r_rd_bank] & io_bus.out_ready;
  assign w_wr_wrap = (r_wr_cnt == CNT_LAST);
  assign w_rd_wrap = (r_rd_cnt == CNT_LAST);

  // Bit-reversed read index.
  always_comb begin
    w_rev_cnt = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      w_rev_cnt[ADDR_W-1-i] = r_rd_cnt[i];
    end
  end

`ifdef BITREV_BYPASS_EN
  logic [1:0] r_byp;

  // Mode flag latched with the first sample of each frame, per bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp <= '0;
    end else if (w_in_acc && (r_wr_cnt == '0)) begin
      r_byp[r_wr_bank] <= io_bus.bypass;
    end
  end

  assign w_rd_addr = r_byp[r_rd_bank] ? r_rd_cnt : w_rev_cnt;
`else
  assign w_rd_addr = w_rev_cnt;
`endif

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_mem[r_wr_bank][r_wr_cnt] <= io_bus.in_data;
    end
  end

  // Bank/counter bookkeeping. A set and a clear in the same cycle always hit
  // different banks, so both per-bit updates stand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_in_acc) begin
        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        if (w_wr_wrap) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end
      end
      if (w_out_acc) begin
        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
        if (w_rd_wrap) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
        end
      end
    end
  end

  assign io_bus.in_ready  = ~r_full[r_wr_bank];
  assign io_bus.out_valid = r_full[r_rd_bank];
  assign io_bus.out_last  = r_full[r_rd_bank] & w_rd_wrap;
  assign io_bus.out_data  = r_mem[r_rd_bank][w_rd_addr];

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Purpose : directed self-checking bench for bitrev_reorder_ctrl (N=8, DATA_W=8).
//           Input samples carry their running index; expected output order is
//           frame*8 + rev3(position).
// Macro   : BITREV_BYPASS_EN enables the bypass frame sequence.
module tb_bitrev_reorder_ctrl;

  logic clk;
  logic rst_n;

  bitrev_reorder_ctrl_if #(.DATA_W(8)) bus ();

  bitrev_reorder_ctrl #(.ADDR_W(3), .DATA_W(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         in_sent;
  int         out_got;
  int         cyc;
  int         first_in_cyc;
  int         first_out_cyc;
  bit         byp_first;
  bit         prev_hold;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [7:0] cap [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected k-th output sample of the stream.
  function automatic logic [7:0] exp_data(input int k);
    logic [2:0] p;
    p = 3'(k);
    if (byp_first && k < 8) return 8'(k);
    return 8'((k / 8) * 8 + int'({p[0], p[1], p[2]}));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef BITREV_BYPASS_EN
    bus.bypass    = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    in_sent       = 0;
    out_got       = 0;
    cyc           = 0;
    first_in_cyc  = -1;
    first_out_cyc = -1;
    prev_hold     = 1'b0;
  endtask

  // mode: 0 = always, 1 = never, 2 = random ~50%
  task automatic run(input int cycles, input int in_mode, input int out_mode,
                     input int in_limit, input bit chk_rdy);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.in_valid  = (in_sent < in_limit) &&
                      (in_mode == 0 || (in_mode == 2 && $urandom_range(0, 1) == 1));
      bus.in_data   = 8'(in_sent);
      bus.out_ready = (out_mode == 0) || (out_mode == 2 && $urandom_range(0, 1) == 1);
`ifdef BITREV_BYPASS_EN
      bus.bypass    = byp_first && (in_sent < 8);
`endif
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data",  32'(bus.out_data),  32'(prev_data));
        chk("hold_last",  32'(bus.out_last),  32'(prev_last));
      end
      if (bus.out_valid) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        chk("out_data", 32'(bus.out_data), 32'(exp_data(out_got)));
        chk("out_last", 32'(bus.out_last), 32'(out_got % 8 == 7));
      end
      if (chk_rdy) chk("in_ready_steady", 32'(bus.in_ready), 32'd1);
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        in_sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_got < 8) cap[out_got] = bus.out_data;
        out_got++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    prev_hold     = 1'b0;
  endtask

  logic [7:0] exp1 [8];

  initial begin
    rst_n     = 1'b0;
    byp_first = 1'b0;
    exp1      = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};

    // 1: single frame, latency and order
    do_reset();
    run(20, 0, 0, 8, 1'b0);
    chk("t1_count",   32'(out_got), 32'd8);
    chk("t1_latency", 32'(first_out_cyc - first_in_cyc), 32'd8);
    for (int i = 0; i < 8; i++) chk("t1_order", 32'(cap[i]), 32'(exp1[i]));

    // 2: three frames streamed, in_ready never drops
    do_reset();
    run(40, 0, 0, 24, 1'b1);
    chk("t2_count", 32'(out_got), 32'd24);

    // 3: back-pressure with both banks full
    do_reset();
    run(20, 0, 1, 24, 1'b0);
    chk("t3_accepts_blocked", 32'(in_sent), 32'd16);
    chk("t3_in_ready_low",    32'(bus.in_ready), 32'd0);
    chk("t3_out_valid",       32'(bus.out_valid), 32'd1);
    run(7, 0, 0, 24, 1'b0);
    chk("t3_in_ready_after7", 32'(bus.in_ready), 32'd0);
    run(1, 0, 0, 24, 1'b0);
    chk("t3_in_ready_after8", 32'(bus.in_ready), 32'd1);
    chk("t3_out8",            32'(out_got), 32'd8);
    chk("t3_in_held",         32'(in_sent), 32'd16);
    run(40, 0, 0, 24, 1'b0);
    chk("t3_count", 32'(out_got), 32'd24);

    // 4: random duty on both sides, 100 frames
    do_reset();
    run(4000, 2, 2, 800, 1'b0);
    run(100, 1, 0, 800, 1'b0);
    chk("t4_count", 32'(out_got), 32'd800);

    // 5: reset after a partial frame
    do_reset();
    run(5, 0, 1, 5, 1'b0);
    chk("t5_partial", 32'(in_sent), 32'd5);
    do_reset();
    run(20, 0, 0, 8, 1'b0);
    chk("t5_count", 32'(out_got), 32'd8);
    for (int i = 0; i < 8; i++) chk("t5_order", 32'(cap[i]), 32'(exp1[i]));

`ifdef BITREV_BYPASS_EN
    // 6: bypass frame followed by a reversed frame
    do_reset();
    byp_first = 1'b1;
    run(30, 0, 0, 16, 1'b0);
    chk("t6_count", 32'(out_got), 32'd16);
    for (int i = 0; i < 8; i++) chk("t6_natural", 32'(cap[i]), 32'(i));
    byp_first = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
